// File: rtl/avalon_console_agent.sv
`default_nettype none
// ============================================================================
// Module      : avalon_console_agent
// Description : Avalon-MM console agent. CPU stores bytes into a TX FIFO and
//               the block serialises them as 8N1 frames on txd, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_console_agent #(
    parameter int FIFO_DEPTH      = 16,
    parameter int DEFAULT_DIVISOR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        txd
);

    localparam int              c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL    = FIFO_DEPTH[c_AW:0];
    localparam logic [c_AW:0]   c_CNT_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW-1:0] c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]     c_DEF_DIV = DEFAULT_DIVISOR[15:0];

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_DIV    = 2'd2;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [15:0]     r_divisor, r_bit_div, r_baud;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [1:0]      r_state;
    logic            r_txd, r_rd_phase;
    logic [31:0]     r_readdata;

    logic [1:0]  w_sel;
    logic        w_full, w_empty, w_busy;
    logic        w_rd_first, w_data_wr, w_push, w_pop, w_frame_end, w_div_wr;
    logic [15:0] w_div_merged, w_div_next;
    logic [7:0]  w_count8;
    logic [31:0] w_reg_val;
    logic        w_unused;

    assign w_sel       = address[3:2];
    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != c_ST_IDLE);
    assign w_rd_first  = read && !write && !r_rd_phase;
    assign w_data_wr   = write && (w_sel == c_REG_DATA) && byteenable[0];
    assign w_push      = w_data_wr && !w_full;
    assign w_frame_end = (r_state == c_ST_STOP) && (r_baud == 16'd0);
    assign w_pop       = ((r_state == c_ST_IDLE) || w_frame_end) && !w_empty;
    assign w_div_wr    = write && (w_sel == c_REG_DIV);
    assign w_count8    = 8'(r_count);
    assign w_unused    = ^{writedata[31:16], address[1:0], byteenable[3:2]};

    assign w_div_merged = {byteenable[1] ? writedata[15:8] : r_divisor[15:8],
                           byteenable[0] ? writedata[7:0]  : r_divisor[7:0]};
    assign w_div_next   = (w_div_merged == 16'd0) ? 16'd1 : w_div_merged;

    // Stall decision uses the registered full flag, so a same-cycle pop
    // only releases a blocked push on the following cycle.
    assign waitrequest = w_rd_first || (w_data_wr && w_full);
    assign readdata    = r_readdata;
    assign txd         = r_txd;

    always_comb begin
        w_reg_val = 32'd0;
        case (w_sel)
            c_REG_STATUS: w_reg_val = {16'd0, w_count8, 5'd0, w_busy, w_empty, w_full};
            c_REG_DIV:    w_reg_val = {16'd0, r_divisor};
            default:      w_reg_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divisor  <= c_DEF_DIV;
            r_readdata <= 32'd0;
            r_rd_phase <= 1'b0;
        end else begin
            if (w_div_wr) r_divisor <= w_div_next;
            if (w_rd_first) r_readdata <= w_reg_val;
            r_rd_phase <= w_rd_first;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_txd     <= 1'b1;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_bit_div <= c_DEF_DIV;
            r_baud    <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bit_div <= r_divisor;
                        r_baud    <= r_divisor - 16'd1;
                        r_state   <= c_ST_START;
                        r_txd     <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (r_baud == 16'd0) begin
                        r_baud    <= r_bit_div - 16'd1;
                        r_bit_cnt <= 3'd0;
                        r_txd     <= r_shift[0];
                        r_state   <= c_ST_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                c_ST_DATA: begin
                    if (r_baud == 16'd0) begin
                        r_baud <= r_bit_div - 16'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                c_ST_STOP: begin
                    if (r_baud != 16'd0) begin
                        r_baud <= r_baud - 16'd1;
                    end else if (w_pop) begin
                        // Back-to-back frame: no idle bit between stop and start
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bit_div <= r_divisor;
                        r_baud    <= r_divisor - 16'd1;
                        r_state   <= c_ST_START;
                        r_txd     <= 1'b0;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_txd   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_console_agent.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_console_agent
// Description : Scoreboard bench for avalon_console_agent: bus transactions
//               push expectations, monitors decode readdata and txd frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_console_agent;

    localparam int DEPTH   = 16;
    localparam int DEF_DIV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        txd;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] rd_q[$];
    int          model_div = DEF_DIV;
    logic        mon_active = 1'b0;
    int          mon_cyc = 0;
    int          mon_div = 1;
    logic [9:0]  mon_bits = '1;

    avalon_console_agent #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(DEF_DIV)) dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .waitrequest(waitrequest), .txd(txd)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = exp_q.size();
        return {16'd0, 8'(n), 5'd0, mon_active, (n == 0), (n == DEPTH)};
    endfunction

    function automatic logic [31:0] model_reg(input logic [3:0] a);
        case (a[3:2])
            2'd1:    return model_status();
            2'd2:    return 32'(model_div);
            default: return 32'd0;
        endcase
    endfunction

    // Frame decoder: each frame is 10 bits of mon_div cycles, divisor as seen at start
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
            chk("txd_in_reset", {31'd0, txd}, 32'd1);
        end else begin
            if (mon_active && mon_cyc == 10 * mon_div) mon_active = 1'b0;
            if (!mon_active && txd == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txd_unexpected_start actual=0 required=1 t=%0t", $time);
                end else begin
                    mon_bits   = {1'b1, exp_q.pop_front(), 1'b0};
                    mon_div    = model_div;
                    mon_cyc    = 0;
                    mon_active = 1'b1;
                end
            end
            if (mon_active && mon_cyc < 10 * mon_div) begin
                chk("txd_bit", {31'd0, txd}, {31'd0, mon_bits[mon_cyc / mon_div]});
                mon_cyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && read && !write && !waitrequest) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected actual=%h required=none", readdata);
            end else begin
                chk("readdata", readdata, rd_q.pop_front());
            end
        end
    end

    task automatic bus_read(input logic [3:0] a);
        address = a; read = 1'b1; write = 1'b0;
        @(negedge clk); #1;
        chk("rd_wait_c1", {31'd0, waitrequest}, 32'd1);
        rd_q.push_back(model_reg(a));
        @(posedge clk); #1;
        chk("rd_wait_c2", {31'd0, waitrequest}, 32'd0);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be,
                             input logic also_read, output int stalls);
        logic exp_w, ok;
        logic [15:0] nd;
        address = a; writedata = wd; byteenable = be; write = 1'b1; read = also_read;
        stalls = 0; ok = 1'b1;
        while (1) begin
            @(negedge clk); #1;
            exp_w = (a[3:2] == 2'd0) && be[0] && (exp_q.size() == DEPTH);
            chk("wr_waitrequest", {31'd0, waitrequest}, {31'd0, exp_w});
            if (!waitrequest) break;
            stalls++;
            if (stalls > 5000) begin
                checks++;
                errors++;
                $display("FAIL wr_timeout actual=stalled required=accepted");
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        if (ok) begin
            if (a[3:2] == 2'd0 && be[0]) exp_q.push_back(wd[7:0]);
            if (a[3:2] == 2'd2) begin
                nd = model_div[15:0];
                if (be[0]) nd[7:0]  = wd[7:0];
                if (be[1]) nd[15:8] = wd[15:8];
                if (nd == 16'd0) nd = 16'd1;
                model_div = int'(nd);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((exp_q.size() != 0 || mon_active) && n < 20000);
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int st, n, lim;
        logic [3:0] be;
        rst = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_waitrequest", {31'd0, waitrequest}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Status after reset
        bus_read(4'h4);
        chk("status_after_reset_model", model_status(), 32'h0000_0002);

        // Single 0x55 frame at divisor 4, with start-bit latency
        bus_write(4'h8, 32'd4, 4'hF, 1'b0, st);
        bus_write(4'h0, 32'h55, 4'h1, 1'b0, st);
        @(negedge clk); chk("latency_c2", {31'd0, txd}, 32'd1);
        @(negedge clk); chk("latency_c3", {31'd0, txd}, 32'd0);
        @(posedge clk); #1;
        wait_idle();
        bus_read(4'h4);

        // Back-to-back burst that overfills the FIFO at divisor 2
        bus_write(4'h8, 32'd2, 4'h3, 1'b0, st);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus_write(4'h0, 32'(i), 4'h1, 1'b0, st);
            if (i == DEPTH + 1) chk("burst_last_stalled", {31'd0, (st > 0)}, 32'd1);
        end
        wait_idle();

        // Lane-0 disabled data write and reserved write are no-ops
        bus_write(4'h0, 32'hAB, 4'b1110, 1'b0, st);
        bus_write(4'hC, 32'hFF, 4'hF, 1'b0, st);
        bus_write(4'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, st);
        repeat (20) @(posedge clk);
        #1;
        bus_read(4'h4);
        bus_read(4'hC);
        bus_read(4'h0);

        // Divisor 0 stored as 1; mid-frame divisor change applies to next frame only
        bus_write(4'h8, 32'd0, 4'h3, 1'b0, st);
        bus_read(4'h8);
        bus_write(4'h8, 32'd3, 4'h3, 1'b0, st);
        bus_write(4'h0, 32'hA5, 4'h1, 1'b0, st);
        bus_write(4'h0, 32'h3C, 4'h1, 1'b1, st);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mon_active && mon_cyc >= 12) && n < 1000);
        @(posedge clk); #1;
        bus_write(4'h8, 32'd8, 4'h3, 1'b0, st);
        bus_read(4'h4);
        wait_idle();

        // Randomised traffic
        for (int it = 0; it < 20; it++) begin
            bus_write(4'h8, 32'($urandom_range(0, 4)), 4'($urandom), 1'b0, st);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                be = 4'($urandom);
                if ($urandom_range(0, 3) != 0) be[0] = 1'b1;
                bus_write(4'h0, $urandom, be, 1'($urandom), st);
            end
            case ($urandom_range(0, 2))
                0:       bus_read(4'h8);
                1:       bus_read(4'hC);
                default: bus_read(4'h4);
            endcase
            wait_idle();
            bus_read(4'h4);
        end

        // Asynchronous reset during data bit 3 with 5 bytes queued
        bus_write(4'h8, 32'd4, 4'h3, 1'b0, st);
        for (int j = 0; j < 6; j++) bus_write(4'h0, 32'(8'hC0 + j), 4'h1, 1'b0, st);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mon_active && mon_cyc == 18) && n < 1000);
        lim = exp_q.size();
        chk("queued_before_reset", 32'(lim), 32'd5);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        model_div = DEF_DIV;
        #1;
        chk("txd_async_reset", {31'd0, txd}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus_read(4'h4);
        bus_read(4'h8);
        repeat (50) @(posedge clk);
        #1;

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
